// File: rtl/pinmux_pkg.sv
// Shared types and constants for the pad multiplexer.
// func_sel_t is the FUNC_SEL field type for the default 4-function build;
// the top derives its own select width from NUM_FUNCS via sel_width().
package pinmux_pkg;

    localparam int unsigned DEF_NUM_FUNCS = 4;
    localparam int unsigned SEL_W         = $clog2(DEF_NUM_FUNCS);

    typedef logic [SEL_W-1:0] func_sel_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GAP   = 2'd1,
        APPLY = 2'd2
    } state_t;

    // Register word offsets relative to NUM_PINS (FUNC_SEL occupies 0..NUM_PINS-1)
    localparam int unsigned LOCK_OFS   = 0;
    localparam int unsigned STATUS_OFS = 1;

    // Bit width needed to hold values 0..n-1, never less than 1
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/pinmux_in_sync.sv
// One pad input: 2-flop synchroniser, optionally followed by a glitch filter
// (enabled by macro PINMUX_GLITCH_FILTER_EN).
// Ports: clk, reset (sync, active high), din (raw pad), dout (synchronised/filtered).
module pinmux_in_sync
    import pinmux_pkg::*;
#(
    parameter int unsigned FILTER_CYCLES = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic dout
);

    if (FILTER_CYCLES < 1) begin : g_bad_cfg
        $error("pinmux_in_sync: FILTER_CYCLES must be >= 1");
    end

    logic [1:0] sync_q;

    // Metastability synchroniser
    always_ff @(posedge clk) begin
        if (reset) sync_q <= '0;
        else       sync_q <= {sync_q[0], din};
    end

`ifdef PINMUX_GLITCH_FILTER_EN
    localparam int unsigned CNT_W = sel_width(FILTER_CYCLES);

    logic [CNT_W-1:0] stable_cnt;
    logic             filt_q;

    // Output flips only after FILTER_CYCLES consecutive samples that differ from it
    always_ff @(posedge clk) begin
        if (reset) begin
            stable_cnt <= '0;
            filt_q     <= 1'b0;
        end else if (sync_q[1] == filt_q) begin
            stable_cnt <= '0;
        end else if (stable_cnt == CNT_W'(FILTER_CYCLES - 1)) begin
            filt_q     <= sync_q[1];
            stable_cnt <= '0;
        end else begin
            stable_cnt <= stable_cnt + CNT_W'(1);
        end
    end

    assign dout = filt_q;
`else
    assign dout = sync_q[1];
`endif

endmodule

// File: rtl/pinmux_ctrl.sv
// Register-programmable pad multiplexer with break-before-make function switching.
// Optional glitch filter on pad inputs: define PINMUX_GLITCH_FILTER_EN.
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   reg_sel/reg_we/reg_addr/reg_wdata/reg_rdata  register bus (rdata 1 cycle after sel)
//   gpio_o/gpio_oen/gpio_i     GPIO side (function 0), oen active low
//   periph_o/periph_oen        alternate functions 1..NUM_FUNCS-1
//   periph_i                   synchronised pad inputs (same as gpio_i)
//   pad_i/pad_o/pad_oen        pad ring, pad_oen active low (1 = tristate)
module pinmux_ctrl
    import pinmux_pkg::*;
#(
    parameter int unsigned NUM_PINS      = 32,
    parameter int unsigned NUM_FUNCS     = 4,
    parameter int unsigned GAP_CYCLES    = 4,
    parameter int unsigned FILTER_CYCLES = 3
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 reg_sel,
    input  logic                                 reg_we,
    input  logic [$clog2(NUM_PINS+2)-1:0]        reg_addr,
    input  logic [31:0]                          reg_wdata,
    output logic [31:0]                          reg_rdata,
    input  logic [NUM_PINS-1:0]                  gpio_o,
    input  logic [NUM_PINS-1:0]                  gpio_oen,
    output logic [NUM_PINS-1:0]                  gpio_i,
    input  logic [NUM_FUNCS-1:1][NUM_PINS-1:0]   periph_o,
    input  logic [NUM_FUNCS-1:1][NUM_PINS-1:0]   periph_oen,
    output logic [NUM_PINS-1:0]                  periph_i,
    input  logic [NUM_PINS-1:0]                  pad_i,
    output logic [NUM_PINS-1:0]                  pad_o,
    output logic [NUM_PINS-1:0]                  pad_oen
);

    localparam int unsigned ADDR_W   = $clog2(NUM_PINS + 2);
    localparam int unsigned SEL_BITS = sel_width(NUM_FUNCS);
    localparam int unsigned PIN_W    = sel_width(NUM_PINS);
    localparam int unsigned CNT_W    = sel_width(GAP_CYCLES);

    if (NUM_FUNCS < 2 || GAP_CYCLES < 1) begin : g_bad_cfg
        $error("pinmux_ctrl: NUM_FUNCS must be >= 2 and GAP_CYCLES >= 1");
    end

    state_t                 state;
    logic [CNT_W-1:0]       gap_cnt;
    logic [NUM_PINS-1:0]    pending;
    logic [NUM_PINS-1:0]    set_mask;
    logic                   lock;
    logic [SEL_BITS-1:0]    active_sel [NUM_PINS];
    logic [SEL_BITS-1:0]    shadow_sel [NUM_PINS];
    logic [SEL_BITS-1:0]    drive_sel  [NUM_PINS];
    logic [PIN_W-1:0]       pin_idx;
    logic                   addr_is_pin, addr_is_lock, addr_is_stat;
    logic                   wr_func, wr_lock;
    logic [31:0]            rd_data_c;

    // Register address decode
    assign pin_idx      = reg_addr[PIN_W-1:0];
    assign addr_is_pin  = 32'(reg_addr) < NUM_PINS;
    assign addr_is_lock = reg_addr == ADDR_W'(NUM_PINS + LOCK_OFS);
    assign addr_is_stat = reg_addr == ADDR_W'(NUM_PINS + STATUS_OFS);
    assign wr_func      = reg_sel && reg_we && addr_is_pin && !lock
                          && (reg_wdata < 32'(NUM_FUNCS));
    assign wr_lock      = reg_sel && reg_we && addr_is_lock;

    // During APPLY pending pins already drive the committed shadow value, so the
    // new source appears right after the gap and writes compare against it.
    always_comb begin
        for (int p = 0; p < NUM_PINS; p++) begin
            drive_sel[p] = (state == APPLY && pending[p]) ? shadow_sel[p] : active_sel[p];
        end
    end

    // A write only starts a switch when it changes what the pin drives
    always_comb begin
        set_mask = '0;
        if (wr_func && SEL_BITS'(reg_wdata) != drive_sel[pin_idx]) begin
            set_mask[pin_idx] = 1'b1;
        end
    end

    // Read data mux
    always_comb begin
        rd_data_c = '0;
        if (reg_sel && !reg_we) begin
            if (addr_is_pin)       rd_data_c = 32'(shadow_sel[pin_idx]);
            else if (addr_is_lock) rd_data_c = {31'd0, lock};
            else if (addr_is_stat) rd_data_c = {31'd0, state != IDLE};
        end
    end

    // Register file and break-before-make sequencer
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            gap_cnt   <= '0;
            pending   <= '0;
            lock      <= 1'b0;
            reg_rdata <= '0;
            for (int p = 0; p < NUM_PINS; p++) begin
                active_sel[p] <= '0;
                shadow_sel[p] <= '0;
            end
        end else begin
            reg_rdata <= rd_data_c;
            if (wr_func)                 shadow_sel[pin_idx] <= SEL_BITS'(reg_wdata);
            if (wr_lock && reg_wdata[0]) lock <= 1'b1;

            case (state)
                IDLE: begin
                    pending <= pending | set_mask;
                    if (pending != '0) begin
                        state   <= GAP;
                        gap_cnt <= CNT_W'(GAP_CYCLES - 1);
                    end
                end
                GAP: begin
                    pending <= pending | set_mask;
                    if (set_mask != '0)     gap_cnt <= CNT_W'(GAP_CYCLES - 1);
                    else if (gap_cnt == '0) state   <= APPLY;
                    else                    gap_cnt <= gap_cnt - CNT_W'(1);
                end
                APPLY: begin
                    for (int p = 0; p < NUM_PINS; p++) begin
                        if (pending[p]) active_sel[p] <= shadow_sel[p];
                    end
                    pending <= set_mask;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Output path: pins in their gap are tristated, others follow their source
    always_comb begin
        pad_o   = '0;
        pad_oen = '1;
        for (int p = 0; p < NUM_PINS; p++) begin
            if (state == GAP && pending[p]) begin
                pad_o[p]   = 1'b0;
                pad_oen[p] = 1'b1;
            end else if (drive_sel[p] == '0) begin
                pad_o[p]   = gpio_o[p];
                pad_oen[p] = gpio_oen[p];
            end else begin
                for (int f = 1; f < NUM_FUNCS; f++) begin
                    if (drive_sel[p] == SEL_BITS'(f)) begin
                        pad_o[p]   = periph_o[f][p];
                        pad_oen[p] = periph_oen[f][p];
                    end
                end
            end
        end
    end

    // Input path
    logic [NUM_PINS-1:0] pad_sync;

    for (genvar p = 0; p < NUM_PINS; p++) begin : g_in
        pinmux_in_sync #(.FILTER_CYCLES(FILTER_CYCLES)) u_sync (
            .clk  (clk),
            .reset(reset),
            .din  (pad_i[p]),
            .dout (pad_sync[p])
        );
    end

    assign gpio_i   = pad_sync;
    assign periph_i = pad_sync;

endmodule

// File: tb/tb_pinmux_ctrl.sv
// Directed bench for pinmux_ctrl (default parameters).
module tb_pinmux_ctrl;

    localparam int unsigned NP = 32;
    localparam int unsigned NF = 4;
    localparam int unsigned AW = 6;
    localparam logic [AW-1:0] A_LOCK = AW'(32);
    localparam logic [AW-1:0] A_STAT = AW'(33);
`ifdef PINMUX_GLITCH_FILTER_EN
    localparam int IN_LAT   = 5;
    localparam int PULSE_HI = 0;
`else
    localparam int IN_LAT   = 2;
    localparam int PULSE_HI = 1;
`endif

    logic                    clk = 1'b0;
    logic                    reset;
    logic                    reg_sel, reg_we;
    logic [AW-1:0]           reg_addr;
    logic [31:0]             reg_wdata, reg_rdata;
    logic [NP-1:0]           gpio_o, gpio_oen, gpio_i, periph_i;
    logic [NF-1:1][NP-1:0]   periph_o, periph_oen;
    logic [NP-1:0]           pad_i, pad_o, pad_oen;

    int checks   = 0;
    int failures = 0;

    pinmux_ctrl dut (
        .clk       (clk),
        .reset     (reset),
        .reg_sel   (reg_sel),
        .reg_we    (reg_we),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_rdata (reg_rdata),
        .gpio_o    (gpio_o),
        .gpio_oen  (gpio_oen),
        .gpio_i    (gpio_i),
        .periph_o  (periph_o),
        .periph_oen(periph_oen),
        .periph_i  (periph_i),
        .pad_i     (pad_i),
        .pad_o     (pad_o),
        .pad_oen   (pad_oen)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [AW-1:0] addr, input logic [31:0] data);
        reg_sel = 1'b1; reg_we = 1'b1; reg_addr = addr; reg_wdata = data;
        tick();
        reg_sel = 1'b0; reg_we = 1'b0;
    endtask

    task automatic read_reg(input logic [AW-1:0] addr, output logic [31:0] data);
        reg_sel = 1'b1; reg_we = 1'b0; reg_addr = addr;
        tick();
        data = reg_rdata;
        reg_sel = 1'b0;
    endtask

    task automatic test_reset();
        logic [31:0] d;
        gpio_o[5] = 1'b1; gpio_oen[5] = 1'b0;
        reset = 1'b1;
        tick(); tick();
        reset = 1'b0;
        #1;
        checks++; if (reg_rdata !== 32'd0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", reg_rdata); end
        checks++; if (pad_o[5] !== 1'b1 || pad_oen[5] !== 1'b0) begin failures++; $display("FAIL reset_pad5 got o=%b oen=%b exp o=1 oen=0", pad_o[5], pad_oen[5]); end
        checks++; if (pad_oen[7] !== 1'b1) begin failures++; $display("FAIL reset_pad7_oen got=%b exp=1", pad_oen[7]); end
        checks++; if (gpio_i !== '0) begin failures++; $display("FAIL reset_gpio_i got=%h exp=0", gpio_i); end
        read_reg(AW'(5), d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_funcsel5 got=%0d exp=0", d); end
        read_reg(A_STAT, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL reset_status got=%0d exp=0", d); end
    endtask

    task automatic test_func_switch();
        logic [31:0] d;
        int          tri_cnt = 0;
        periph_o[2][5] = 1'b0; periph_oen[2][5] = 1'b0;
        write_reg(AW'(5), 32'd2);
        for (int i = 0; i < 12; i++) begin
            if (pad_oen[5] === 1'b1) tri_cnt++;
            tick();
        end
        checks++; if (tri_cnt != 4) begin failures++; $display("FAIL switch_gap_len got=%0d exp=4", tri_cnt); end
        checks++; if (pad_o[5] !== 1'b0 || pad_oen[5] !== 1'b0) begin failures++; $display("FAIL switch_follow0 got o=%b oen=%b exp o=0 oen=0", pad_o[5], pad_oen[5]); end
        periph_o[2][5] = 1'b1; #1;
        checks++; if (pad_o[5] !== 1'b1) begin failures++; $display("FAIL switch_follow1 got=%b exp=1", pad_o[5]); end
        periph_oen[2][5] = 1'b1; #1;
        checks++; if (pad_oen[5] !== 1'b1) begin failures++; $display("FAIL switch_follow_oen got=%b exp=1", pad_oen[5]); end
        periph_oen[2][5] = 1'b0;
        read_reg(AW'(5), d);
        checks++; if (d !== 32'd2) begin failures++; $display("FAIL switch_readback got=%0d exp=2", d); end
        read_reg(A_STAT, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL switch_busy_done got=%0d exp=0", d); end
    endtask

    task automatic test_busy();
        logic [31:0] d;
        write_reg(AW'(7), 32'd1);
        tick();
        read_reg(A_STAT, d);
        checks++; if (d !== 32'd1) begin failures++; $display("FAIL busy_during_gap got=%0d exp=1", d); end
        repeat (8) tick();
        read_reg(A_STAT, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL busy_after_apply got=%0d exp=0", d); end
        // Same value as already active: no switch should start
        write_reg(AW'(7), 32'd1);
        tick();
        read_reg(A_STAT, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL busy_same_value got=%0d exp=0", d); end
    endtask

    task automatic test_back_to_back();
        int cnt5 = 0, cnt6 = 0, last5 = -1, last6 = -1;
        periph_o[1][5] = 1'b1; periph_oen[1][5] = 1'b0;
        periph_o[3][6] = 1'b1; periph_oen[3][6] = 1'b0;
        gpio_o[6] = 1'b0; gpio_oen[6] = 1'b0;
        for (int i = 0; i < 15; i++) begin
            reg_sel = (i == 0 || i == 3); reg_we = reg_sel;
            reg_addr  = (i == 3) ? AW'(6) : AW'(5);
            reg_wdata = (i == 3) ? 32'd3 : 32'd1;
            tick();
            reg_sel = 1'b0; reg_we = 1'b0;
            if (pad_oen[5] === 1'b1) begin cnt5++; last5 = i; end
            if (pad_oen[6] === 1'b1) begin cnt6++; last6 = i; end
        end
        checks++; if (cnt5 != 6) begin failures++; $display("FAIL b2b_pin5_gap got=%0d exp=6", cnt5); end
        checks++; if (cnt6 != 4) begin failures++; $display("FAIL b2b_pin6_gap got=%0d exp=4", cnt6); end
        checks++; if (last5 != 6 || last6 != 6) begin failures++; $display("FAIL b2b_same_apply got last5=%0d last6=%0d exp 6/6", last5, last6); end
        checks++; if (pad_o[5] !== 1'b1 || pad_oen[5] !== 1'b0 || pad_o[6] !== 1'b1 || pad_oen[6] !== 1'b0) begin
            failures++; $display("FAIL b2b_final got o5=%b oen5=%b o6=%b oen6=%b exp 1 0 1 0", pad_o[5], pad_oen[5], pad_o[6], pad_oen[6]);
        end
    endtask

    task automatic test_input_sync();
        int first = -1, hi = 0;
        pad_i[9] = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (first < 0 && gpio_i[9] === 1'b1) first = i;
        end
        checks++; if (first != IN_LAT - 1) begin failures++; $display("FAIL sync_latency got=%0d exp=%0d", first + 1, IN_LAT); end
        checks++; if (periph_i !== 32'h0000_0200) begin failures++; $display("FAIL sync_periph_i got=%h exp=00000200", periph_i); end
        pad_i[9] = 1'b0;
        repeat (10) tick();
        checks++; if (gpio_i[9] !== 1'b0) begin failures++; $display("FAIL sync_fall got=%b exp=0", gpio_i[9]); end
        pad_i[9] = 1'b1;
        tick();
        pad_i[9] = 1'b0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (gpio_i[9] === 1'b1) hi++;
        end
        checks++; if (hi != PULSE_HI) begin failures++; $display("FAIL sync_pulse got=%0d exp=%0d", hi, PULSE_HI); end
    endtask

    task automatic test_invalid_and_lock();
        logic [31:0] d;
        write_reg(AW'(3), 32'd4);
        read_reg(AW'(3), d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL inval_sel got=%0d exp=0", d); end
        read_reg(A_STAT, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL inval_busy got=%0d exp=0", d); end
        read_reg(AW'(40), d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL oor_read got=%0d exp=0", d); end
        write_reg(A_LOCK, 32'd1);
        read_reg(A_LOCK, d);
        checks++; if (d !== 32'd1) begin failures++; $display("FAIL lock_set got=%0d exp=1", d); end
        write_reg(AW'(3), 32'd1);
        tick();
        read_reg(A_STAT, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL lock_busy got=%0d exp=0", d); end
        read_reg(AW'(3), d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL lock_sel got=%0d exp=0", d); end
        read_reg(AW'(5), d);
        checks++; if (d !== 32'd1) begin failures++; $display("FAIL lock_read_valid got=%0d exp=1", d); end
        write_reg(A_LOCK, 32'd0);
        read_reg(A_LOCK, d);
        checks++; if (d !== 32'd1) begin failures++; $display("FAIL lock_sticky got=%0d exp=1", d); end
    endtask

    task automatic test_reset_mid_gap();
        logic [31:0] d;
        reset = 1'b1; tick(); reset = 1'b0;
        write_reg(AW'(5), 32'd2);
        write_reg(A_LOCK, 32'd1);
        checks++; if (pad_oen[5] !== 1'b1) begin failures++; $display("FAIL rgap_in_gap got=%b exp=1", pad_oen[5]); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++; if (pad_o[5] !== 1'b1 || pad_oen[5] !== 1'b0) begin failures++; $display("FAIL rgap_gpio got o=%b oen=%b exp o=1 oen=0", pad_o[5], pad_oen[5]); end
        checks++; if (pad_o[6] !== 1'b0 || pad_oen[6] !== 1'b0) begin failures++; $display("FAIL rgap_pin6_gpio got o=%b oen=%b exp o=0 oen=0", pad_o[6], pad_oen[6]); end
        read_reg(A_STAT, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL rgap_busy got=%0d exp=0", d); end
        read_reg(A_LOCK, d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL rgap_lock got=%0d exp=0", d); end
        read_reg(AW'(5), d);
        checks++; if (d !== 32'd0) begin failures++; $display("FAIL rgap_sel got=%0d exp=0", d); end
    endtask

    initial begin
        reset = 1'b1; reg_sel = 1'b0; reg_we = 1'b0; reg_addr = '0; reg_wdata = '0;
        gpio_o = '0; gpio_oen = '1; pad_i = '0;
        periph_o = '0; periph_oen = '1;
        test_reset();
        test_func_switch();
        test_busy();
        test_back_to_back();
        test_input_sync();
        test_invalid_and_lock();
        test_reset_mid_gap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
